// File: rtl/bram_window_reader.sv
// Raster/window read controller for a read-only image BRAM with configurable read latency.
// Pixels leave on a valid/ready stream tagged with row/col/last through a credit-limited skid FIFO.
module bram_window_reader #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 18,
    parameter int IMG_ROWS = 360,
    parameter int IMG_COLS = 540,
    parameter int ROW_W    = 10,
    parameter int COL_W    = 10,
    parameter int RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ROW_W-1:0]  win_row_i,
    input  logic [COL_W-1:0]  win_col_i,
    input  logic [ROW_W-1:0]  win_h_i,
    input  logic [COL_W-1:0]  win_w_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] d2mem_o,
    input  logic [DATA_W-1:0] mem2d_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ROW_W-1:0]  row_o,
    output logic [COL_W-1:0]  col_o,
    output logic              last_o
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ROW_W:0] ROW_LIM = IMG_ROWS;
    localparam logic [COL_W:0] COL_LIM = IMG_COLS;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } ent_t;

    logic [2:0]        state;
    logic              mode_r, err_r;
    logic [ROW_W-1:0]  row_r, h_r, r_off;
    logic [COL_W-1:0]  col_r, w_r, c_off;
    logic [ADDR_W-1:0] row_base, addr;
    logic [RD_LAT:1]   vld_pipe;
    tag_t              tag_pipe [RD_LAT:1];
    ent_t              mem [DEPTH];
    ent_t              head;
    tag_t              cur_tag;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, inflight;
    logic [ROW_W-1:0]  g_row, g_h;
    logic [COL_W-1:0]  g_col, g_w;
    logic              reject, issue, col_end, row_end, push, pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        g_row  = mode_r ? win_row_i : '0;
        g_col  = mode_r ? win_col_i : '0;
        g_h    = mode_r ? win_h_i : ROW_W'(IMG_ROWS);
        g_w    = mode_r ? win_w_i : COL_W'(IMG_COLS);
        reject = (g_h == '0) || (g_w == '0) ||
                 (({1'b0, g_row} + {1'b0, g_h}) > ROW_LIM) ||
                 (({1'b0, g_col} + {1'b0, g_w}) > COL_LIM);
    end

    // Credits count reads still in the BRAM pipe plus FIFO entries, so a full
    // stall can never overflow the FIFO.
    always_comb begin
        inflight = '0;
        for (int k = 1; k <= RD_LAT; k++)
            inflight = inflight + CNT_W'(vld_pipe[k]);
    end

    assign issue   = (state == S_ISSUE) && ((inflight + count) < CNT_W'(DEPTH));
    assign col_end = (c_off == w_r - COL_W'(1));
    assign row_end = (r_off == h_r - ROW_W'(1));

    always_comb begin
        cur_tag.row  = row_r + r_off;
        cur_tag.col  = col_r + c_off;
        cur_tag.last = col_end && row_end;
    end

    assign head    = mem[rd_ptr];
    assign push    = vld_pipe[RD_LAT];
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign data_o  = valid_o ? head.data : '0;
    assign row_o   = valid_o ? head.tag.row : '0;
    assign col_o   = valid_o ? head.tag.col : '0;
    assign last_o  = valid_o ? head.tag.last : 1'b0;
    assign ena_o   = issue;
    assign wea_o   = 1'b0;
    assign d2mem_o = '0;
    assign addr_o  = addr;
    assign busy_o  = (state != S_IDLE) && (state != S_DONE);
    assign done_o  = (state == S_DONE);
    assign err_o   = done_o && err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_r   <= 1'b0;
            err_r    <= 1'b0;
            row_r    <= '0;
            col_r    <= '0;
            h_r      <= '0;
            w_r      <= '0;
            r_off    <= '0;
            c_off    <= '0;
            row_base <= '0;
            addr     <= '0;
            vld_pipe <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            vld_pipe[1] <= issue;
            for (int k = 2; k <= RD_LAT; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                S_IDLE: if (start_i) begin
                    mode_r <= mode_i;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    row_r <= g_row;
                    col_r <= g_col;
                    h_r   <= g_h;
                    w_r   <= g_w;
                    err_r <= reject;
                    state <= reject ? S_DONE : S_ADDR;
                end
                S_ADDR: begin
                    row_base <= ADDR_W'(row_r) * ADDR_W'(IMG_COLS) + ADDR_W'(col_r);
                    addr     <= ADDR_W'(row_r) * ADDR_W'(IMG_COLS) + ADDR_W'(col_r);
                    r_off    <= '0;
                    c_off    <= '0;
                    state    <= S_ISSUE;
                end
                S_ISSUE: if (issue) begin
                    if (col_end) begin
                        c_off <= '0;
                        if (row_end) begin
                            state <= S_DRAIN;
                        end else begin
                            row_base <= row_base + ADDR_W'(IMG_COLS);
                            addr     <= row_base + ADDR_W'(IMG_COLS);
                            r_off    <= r_off + ROW_W'(1);
                        end
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        c_off <= c_off + COL_W'(1);
                    end
                end
                S_DRAIN: if (pop && head.tag.last) state <= S_DONE;
                S_DONE: begin
                    err_r <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage carries no reset; valid bits and occupancy decide what is live.
    always_ff @(posedge clk) begin
        tag_pipe[1] <= cur_tag;
        for (int k = 2; k <= RD_LAT; k++)
            tag_pipe[k] <= tag_pipe[k-1];
        if (push) mem[wr_ptr] <= '{data: mem2d_i, tag: tag_pipe[RD_LAT]};
    end
endmodule

// File: doc/bram_window_reader.md
Name: bram_window_reader

Overview:
- Parametrised next-generation BRAM read controller for the image path.
- Reads either the full frame in raster order or an arbitrary rectangular window from a read-only BRAM with a configurable read latency.
- Emits pixels on a valid/ready stream with row/col tags; downstream backpressure is honoured via a credit-limited skid FIFO.
- Sits between the image BRAM and the preprocess/VGA consumers, driven by the top-level controller.

Parameters:
DATA_W, 8, pixel width in bits
ADDR_W, 18, BRAM address width
IMG_ROWS, 360, image height in pixels
IMG_COLS, 540, image width in pixels
ROW_W, 10, width of row coordinates/sizes
COL_W, 10, width of col coordinates/sizes
RD_LAT, 2, BRAM read latency in cycles (1..4); FIFO depth is RD_LAT+2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  start request; accepted only in IDLE
mode_i  in  1  0 = full frame, 1 = window; sampled with start_i
win_row_i  in  ROW_W  window top row
win_col_i  in  COL_W  window left col
win_h_i  in  ROW_W  window height (rows)
win_w_i  in  COL_W  window width (cols)
busy_o  out  1  high from start acceptance until done_o
done_o  out  1  one-cycle pulse at end of job
err_o  out  1  one-cycle pulse coincident with done_o when the window was rejected
ena_o  out  1  BRAM enable, one read per high cycle
wea_o  out  1  constant 0
addr_o  out  ADDR_W  BRAM read address
d2mem_o  out  DATA_W  constant 0
mem2d_i  in  DATA_W  BRAM read data, valid RD_LAT cycles after ena_o
data_o  out  DATA_W  pixel
valid_o  out  1  stream valid
ready_i  in  1  stream ready; a beat transfers on valid_o & ready_i
row_o  out  ROW_W  image row of data_o
col_o  out  COL_W  image col of data_o
last_o  out  1  marks the final beat of the job

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO, counters and credit/in-flight logic cleared. Reset mid-job aborts the job, flushes the FIFO, and drops in-flight BRAM returns.
- States:
  - IDLE -> SETUP on start_i.
  - SETUP (1 cycle): latch geometry. Mode 0 uses row 0, col 0, h = IMG_ROWS, w = IMG_COLS.
  - Bounds check: if h == 0, w == 0, row+h > IMG_ROWS or col+w > IMG_COLS, go to DONE with err_o; no reads issued.
  - Address: compute row_base = row*IMG_COLS + col (ADDR_W, no truncation for legal windows); go to ISSUE.
  - ISSUE: issue reads. After the final read, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and the last beat has transferred, then go to DONE.
  - DONE: pulse done_o (and err_o if rejected) for 1 cycle, drop busy_o, return to IDLE.
- Issue rule: ena_o = 1 in ISSUE only when (in-flight reads + FIFO occupancy) < RD_LAT+2. The FIFO therefore never overflows regardless of ready_i.
- Address walk:
  - Each issued read increments addr_o by 1 and the issue col counter by 1.
  - At col offset w-1: row_base += IMG_COLS, addr_o <= new row_base, col offset resets to 0, row offset increments.
  - The final read is at row offset h-1, col offset w-1.
- Tag pipeline: row/col/last tags travel through an RD_LAT-deep shift register alongside ena_o. Data and tag are written to the FIFO together when the delayed enable is high.
- Stream:
  - valid_o = FIFO non-empty. data_o/row_o/col_o/last_o come from the FIFO head.
  - These outputs hold stable while valid_o & !ready_i.
- Latency: with ready_i held high, first valid_o occurs RD_LAT+1 cycles after ena_o first rises (1-cycle FIFO registration). Throughput is 1 beat/cycle sustained.
- Simultaneous FIFO push and pop are permitted at any occupancy, including full.
- start_i while busy_o is ignored.
- Geometry inputs are sampled only in SETUP; changes during a job have no effect.
- Mode 0 visits exactly IMG_ROWS*IMG_COLS beats; addresses run 0..IMG_ROWS*IMG_COLS-1 contiguously.

Test Plan:
- Mode 0, ready_i = 1, IMG_ROWS=4, IMG_COLS=6, BRAM[a] = a -> 24 beats with data 0..23; row/col in raster order; last_o on beat 23 (row 3, col 5); done_o 1 cycle after that beat; err_o = 0.
- Mode 1, row=1, col=2, h=2, w=3 on 4x6 image -> addresses 8,9,10,14,15,16; tags (1,2)..(2,4); last_o on the sixth beat.
- Same as above with ready_i toggling 1010… and a 5-cycle stall -> identical data sequence, no loss or duplication; ena_o pauses when credits = RD_LAT+2; outputs stable during the stall.
- Window row=3, col=0, h=2, w=6 on 4 rows -> no ena_o, done_o and err_o pulse together 2 cycles after start, busy_o high for exactly those cycles.
- RD_LAT=1 and RD_LAT=4 builds, 1x1 window at row=0, col=0 -> single beat with last_o=1; first valid_o exactly RD_LAT+1 cycles after ena_o.
- rst asserted mid-ISSUE with FIFO partly full -> next cycle all outputs 0; late BRAM returns not emitted; a fresh start_i then runs a complete, correct job.
